// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit.
// IFU_PERF_CNT_EN (top-level macro) adds the ifu_starve_cnt counter.
package ifu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_e;

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch-side bundle: imem request/grant/response plus the IDU handshake.
// master = fetch unit, slave = memory and decode side.
interface ifu_prefetch_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 15
);

  logic                 imem_req;
  logic [AddrWidth-1:0] imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [DataWidth-1:0] imem_rdata;
  logic                 ifu_valid;
  logic                 idu_ready;
  logic [DataWidth-1:0] ifu_pc;
  logic [DataWidth-1:0] ifu_fetch_inst;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output ifu_valid,
    input  idu_ready,
    output ifu_pc,
    output ifu_fetch_inst
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  ifu_valid,
    output idu_ready,
    input  ifu_pc,
    input  ifu_fetch_inst
  );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of fetch entries; clear wins over push and pop.
// Read data is the registered head slot, so it holds until popped.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter  int unsigned Depth = 4,
  localparam int unsigned CW    = $clog2(Depth) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int unsigned PW = $clog2(Depth);
  localparam logic [CW-1:0] Full = CW'(Depth);

  fetch_entry_t  mem_q [Depth];
  fetch_entry_t  mem_d [Depth];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (cnt_q != Full);
  assign do_pop  = pop && (cnt_q != '0);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      clear: begin
        wr_d  = '0;
        rd_d  = '0;
        cnt_d = '0;
      end
      default: begin
        if (do_push) begin
          mem_d[wr_q] = wdata;
          wr_d        = wr_q + PW'(1);
        end
        if (do_pop) begin
          rd_d = rd_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Decoupled fetch: credit-limited imem requests feeding an in-order queue.
// Define IFU_PERF_CNT_EN to add the ifu_starve_cnt starvation counter.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 15,
  parameter int unsigned          FifoDepth = 4,
  parameter logic [DataWidth-1:0] ResetPc   = '0
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 redirect_valid,
  input  logic [DataWidth-1:0] redirect_pc,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]          ifu_starve_cnt,
`endif
  ifu_prefetch_if.master       bus
);

  localparam int unsigned CW = $clog2(FifoDepth) + 1;
  localparam logic [CW:0] Credits = (CW+1)'(FifoDepth);
  localparam logic [DataWidth-1:0] Incr = DataWidth'(PC_INCR);

  fetch_state_e         state_q, state_d;
  logic [DataWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [DataWidth-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]        out_q, out_d;
  logic [CW-1:0]        disc_q, disc_d;

  logic [CW-1:0] count;
  logic          empty;
  logic          req;
  logic          fire;
  logic          rsp;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;
  logic          unused_pc;

  // Queued plus in-flight never exceeds depth, so a response always fits.
  assign rsp  = bus.imem_rvalid && (out_q != '0);
  assign req  = (state_q == RUN) && !redirect_valid
             && (({1'b0, count} + {1'b0, out_q}) < Credits);
  assign fire = req && bus.imem_gnt;
  assign push = rsp && (disc_q == '0) && !redirect_valid;
  assign pop  = !empty && bus.idu_ready && !redirect_valid;

  assign wr_entry = '{
    pc:   XLEN'(resp_pc_q),
    inst: XLEN'(bus.imem_rdata)
  };

  ifu_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (brq_clk),
    .rst   (brq_rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q;
    disc_d     = disc_q;
    unique case (1'b1)
      redirect_valid: begin
        state_d    = FLUSH;
        fetch_pc_d = redirect_pc;
        resp_pc_d  = redirect_pc;
        out_d      = out_q - CW'(rsp);
        disc_d     = out_q - CW'(rsp);
      end
      default: begin
        state_d = RUN;
        if (fire) begin
          fetch_pc_d = fetch_pc_q + Incr;
        end
        out_d = out_q + CW'(fire) - CW'(rsp);
        if (rsp) begin
          if (disc_q != '0) begin
            disc_d = disc_q - CW'(1);
          end else begin
            resp_pc_d = resp_pc_q + Incr;
          end
        end
      end
    endcase
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= ResetPc;
      resp_pc_q  <= ResetPc;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  assign bus.imem_req       = req;
  assign bus.imem_addr      = fetch_pc_q[AddrWidth+1:2];
  assign bus.ifu_valid      = !empty;
  assign bus.ifu_pc         = DataWidth'(head.pc);
  assign bus.ifu_fetch_inst = DataWidth'(head.inst);

  assign unused_pc = ^{fetch_pc_q[DataWidth-1:AddrWidth+2],
                       fetch_pc_q[1:0]};

`ifdef IFU_PERF_CNT_EN
  logic [31:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if ((state_q == RUN) && bus.idu_ready && empty
        && (starve_q != '1)) begin
      starve_d = starve_q + 32'd1;
    end
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign ifu_starve_cnt = starve_q;
`endif

`ifndef SYNTHESIS
  rvalid_has_credit_a : assert property (
    @(posedge brq_clk) disable iff (brq_rst)
    bus.imem_rvalid |-> (out_q != '0)
  ) else $error("imem_rvalid with no outstanding request");
`endif

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Parametrised successor to the single-register fetch stage: decoupled instruction fetch with an in-order prefetch queue.
- Issues a pipelined request/grant/response stream to instruction memory and buffers returned instructions with their PCs.
- Presents instructions to IDU over a valid/ready handshake, so IDU/IEU stalls become backpressure rather than a global freeze.
- Redirects from branch, JAL or JALR flush the queue and discard stale in-flight responses.

Parameters:
- DataWidth, 32, instruction/PC width
- AddrWidth, 15, word address width to instruction memory
- FifoDepth, 4, prefetch queue entries (power of two, >=2); also max outstanding requests
- ResetPc, 32'h0, first fetch PC after reset

Ports:
- brq_clk  in  1  clock
- brq_rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  taken branch/JAL/JALR from IDU, single-cycle pulse
- redirect_pc  in  DataWidth  target PC, word aligned
- imem_req  out  1  fetch request
- imem_addr  out  AddrWidth  word address = fetch_pc[AddrWidth+1:2]
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  in-order response valid, at least 1 cycle after grant
- imem_rdata  in  DataWidth  response instruction
- ifu_valid  out  1  queue head valid
- idu_ready  in  1  IDU consumes head when ifu_valid & idu_ready
- ifu_pc  out  DataWidth  PC of head entry
- ifu_fetch_inst  out  DataWidth  instruction of head entry

Behaviour:
- Reset (async assert, sync deassert by integrator): fetch_pc=ResetPc, queue empty, outstanding=0, discard=0, FSM=BOOT; imem_req=0, ifu_valid=0, ifu_pc=0, ifu_fetch_inst=0.
- FSM states:
  - BOOT: one cycle, no requests, then RUN.
  - RUN: normal operation.
  - FLUSH: entered on redirect_valid; one cycle with imem_req=0, then RUN. A redirect while in FLUSH stays in FLUSH and takes the new PC.
- Request rule: imem_req=1 in RUN when (count + outstanding) < FifoDepth and redirect_valid=0. Credit scheme: a response can never find the queue full.
- On imem_req & imem_gnt: fetch_pc += 4, wrapping modulo 2^DataWidth; outstanding += 1.
- On imem_rvalid: outstanding -= 1.
  - If discard>0: response dropped, discard -= 1.
  - Otherwise {pc, inst} pushed. PC comes from a response-PC counter that advances by 4 per accepted response and is reloaded on redirect.
- Pop on ifu_valid & idu_ready; head advances next cycle. ifu_pc/ifu_fetch_inst are stable while ifu_valid & !idu_ready.
- Push and pop in the same cycle: count unchanged. An empty queue with a push shows ifu_valid the next cycle (no bypass); minimum latency from grant to ifu_valid is 2 cycles.
- redirect_valid has priority over all other events in its cycle:
  - Queue emptied, including any same-cycle pop/push.
  - fetch_pc and response-PC set to redirect_pc.
  - discard = outstanding minus any rvalid in the same cycle; that rvalid is dropped.
  - ifu_valid=0 the next cycle.
- Count, outstanding and discard are $clog2(FifoDepth)+1 bits and never exceed FifoDepth.
- imem_rvalid with outstanding=0 is a protocol error: ignored, and an assertion fires in simulation.

Optional Feature:
- IFU_PERF_CNT_EN
- Defined: adds output ifu_starve_cnt (32 bits, reset 0), incremented each RUN cycle with idu_ready=1 and ifu_valid=0, saturating at all-ones.
- Undefined: no port, no logic.

Decomposition:
- Package ifu_pkg:
  - fetch_entry_t struct {pc, inst}
  - fetch_state_e enum {BOOT, RUN, FLUSH}
  - PC_INCR=4
- Sub-module ifu_fifo: parametrised synchronous FIFO of fetch_entry_t with push, pop, clear, count, empty. Top holds the FSM, PC counters and credit/discard logic.

Test Plan:
- Reset, memory grants always with 1-cycle response, idu_ready=1 -> PCs 0x0,0x4,0x8... one per cycle after fill; ifu_valid first high 3 cycles after reset release.
- idu_ready=0 with FifoDepth=4 -> exactly 4 grants, then imem_req=0. Release idu_ready -> entries pop in order with no loss.
- 3-cycle response latency, 2 outstanding, redirect_pc=0x100 -> both stale responses dropped; next ifu_pc=0x100, then 0x104.
- redirect_valid in the same cycle as pop and rvalid -> no entry delivered, rvalid dropped, queue empty next cycle.
- ResetPc=32'hFFFF_FFF8 -> ifu_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert brq_rst mid-stream with queue full -> outputs zero immediately (asynchronous), BOOT on release, fetch restarts at ResetPc.
